// File: rtl/wb_sdram_ctrl_ref_timer_pkg.sv
// rtl/wb_sdram_ctrl_ref_timer_pkg.sv - shared types and defaults for the refresh timer
package wb_sdram_ctrl_ref_timer_pkg;

   // 100 us power-up wait and 7.8 us refresh interval at a 100 MHz sdram_clk
   localparam int DEF_INIT_CYCLES  = 10000;
   localparam int DEF_REF_INTERVAL = 780;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ref_state_t;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wb_sdram_ctrl_wrap_cnt.sv
// rtl/wb_sdram_ctrl_wrap_cnt.sv - enabled modulo-N counter with terminal-count pulse
module wb_sdram_ctrl_wrap_cnt
   import wb_sdram_ctrl_ref_timer_pkg::*;
#(
   parameter int N = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_tc
);

   localparam int W = cnt_width(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] r_cnt;

   // tc marks the wrap cycle itself, not the cycle after
   assign o_tc = i_en && (r_cnt == LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_sdram_ctrl_ref_timer.sv
// rtl/wb_sdram_ctrl_ref_timer.sv - power-up delay and auto-refresh request generator with backlog
module wb_sdram_ctrl_ref_timer
   import wb_sdram_ctrl_ref_timer_pkg::*;
#(
   parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
   parameter int REF_INTERVAL = DEF_REF_INTERVAL,
   parameter int MAX_PENDING  = 8,
   parameter int URGENT_LEVEL = 6
) (
   input  logic       sdram_clk,
   input  logic       wb_rst,
   input  logic       ref_ack,
   output logic       dly_100us,
   output logic       ref_req,
   output logic       ref_urgent,
   output logic       ref_ovf,
   output logic [3:0] pending
);

   localparam logic [3:0] MAX_P = 4'(MAX_PENDING);
   localparam logic [3:0] URG_P = 4'(URGENT_LEVEL);

   ref_state_t r_state;
   ref_state_t w_state_nxt;
   logic [3:0] r_pending;
   logic [3:0] w_pending_nxt;
   logic       r_dly;
   logic       r_req;
   logic       r_urgent;
   logic       r_ovf;
   logic       w_ovf_set;
   logic       w_init_tc;
   logic       w_tick;
   logic       w_ack;
   logic       w_in_init;

   assign w_in_init = (r_state == ST_INIT);
   assign w_ack     = ref_ack && !w_in_init;

   wb_sdram_ctrl_wrap_cnt #(.N(INIT_CYCLES)) u_init_cnt (
      .i_clk (sdram_clk),
      .i_rst (wb_rst),
      .i_en  (w_in_init),
      .o_tc  (w_init_tc)
   );

   // interval counter is held cleared for the whole power-up wait
   wb_sdram_ctrl_wrap_cnt #(.N(REF_INTERVAL)) u_int_cnt (
      .i_clk (sdram_clk),
      .i_rst (wb_rst || w_in_init),
      .i_en  (!w_in_init),
      .o_tc  (w_tick)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_ovf_set     = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (w_init_tc) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_tick && !w_ack) begin
               if (r_pending < MAX_P) w_pending_nxt = r_pending + 4'd1;
               else                   w_ovf_set     = 1'b1;
            end else if (w_ack && !w_tick && (r_pending != 4'd0)) begin
               w_pending_nxt = r_pending - 4'd1;
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (wb_rst) begin
         r_state   <= ST_INIT;
         r_pending <= 4'd0;
         r_dly     <= 1'b0;
         r_req     <= 1'b0;
         r_urgent  <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_dly     <= r_dly || (w_state_nxt == ST_RUN);
         r_req     <= (w_pending_nxt != 4'd0);
         r_urgent  <= (w_pending_nxt >= URG_P);
         r_ovf     <= r_ovf || w_ovf_set;
      end
   end

   assign dly_100us  = r_dly;
   assign ref_req    = r_req;
   assign ref_urgent = r_urgent;
   assign ref_ovf    = r_ovf;
   assign pending    = r_pending;

endmodule
